// File: rtl/vx_split_join_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | VX_split_join_pkg : shared types for the SIMT split/join controller        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package VX_split_join_pkg;

   typedef enum logic {
      OP_SPLIT = 1'b0,
      OP_JOIN  = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEF_NUM_THREADS = 4;
   localparam int DEF_PC_W        = 32;

   // Stack entry layout for the default configuration; the controller builds
   // the same layout from its own parameters.
   typedef struct packed {
      logic                       fallthru;
      logic [DEF_NUM_THREADS-1:0] mask;
      logic [DEF_PC_W-1:0]        pc;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   function automatic int entry_width(input int num_threads, input int pc_w);
      return 1 + num_threads + pc_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vx_split_join_ctrl_ipdom_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | VX_ipdom_stack : per-warp reconvergence stack, one slot per split pair     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module VX_ipdom_stack #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 3
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] q1_i,
   input  logic [WIDTH-1:0] q2_i,
   output logic [WIDTH-1:0] d_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int SLOTS = 2 ** DEPTH;

   logic [WIDTH-1:0] q1_mem_q [SLOTS];
   logic [WIDTH-1:0] q2_mem_q [SLOTS];
   logic [SLOTS-1:0] else_done_q;
   logic [DEPTH-1:0] cnt_q;
   logic [DEPTH-1:0] top;

   // Each slot holds both halves of a split; the else half pops first, the
   // fall-through half pops second and frees the slot.
   assign top     = cnt_q - DEPTH'(1);
   assign full_o  = (cnt_q == {DEPTH{1'b1}});
   assign empty_o = (cnt_q == '0);
   assign d_o     = else_done_q[top] ? q1_mem_q[top] : q2_mem_q[top];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q       <= '0;
         else_done_q <= '0;
      end else if (push_i && !full_o) begin
         else_done_q[cnt_q] <= 1'b0;
         cnt_q              <= cnt_q + DEPTH'(1);
      end else if (pop_i && !empty_o) begin
         if (!else_done_q[top]) begin
            else_done_q[top] <= 1'b1;
         end else begin
            cnt_q <= top;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) begin
         q1_mem_q[cnt_q] <= q1_i;
         q2_mem_q[cnt_q] <= q2_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vx_split_join_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_split_join_ctrl : sequences split/join requests onto per-warp stacks    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vx_split_join_ctrl
   import VX_split_join_pkg::*;
#(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4,
   parameter int STACK_DEPTH = 3,
   parameter int PC_W        = 32,
   parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_op,
   input  logic [WID_W-1:0]       req_wid,
   input  logic [NUM_THREADS-1:0] req_tmask,
   input  logic [NUM_THREADS-1:0] req_taken,
   input  logic [PC_W-1:0]        req_else_pc,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WID_W-1:0]       rsp_wid,
   output logic [NUM_THREADS-1:0] rsp_tmask,
   output logic                   rsp_redirect,
   output logic [PC_W-1:0]        rsp_pc,
   output logic                   rsp_err
);

   localparam int ENT_W = entry_width(NUM_THREADS, PC_W);

   typedef struct packed {
      logic                   fallthru;
      logic [NUM_THREADS-1:0] mask;
      logic [PC_W-1:0]        pc;
   } sj_entry_t;

   logic stk_rst_meta_q;
   logic stk_reset_q;
   logic stk_reset;

   state_e                 state_q;
   logic                   req_ready_q;
   op_e                    op_q;
   logic [WID_W-1:0]       wid_q;
   logic [NUM_THREADS-1:0] tmask_q;
   logic [NUM_THREADS-1:0] taken_q;
   logic [PC_W-1:0]        else_pc_q;

   logic                   rsp_valid_q;
   logic [WID_W-1:0]       rsp_wid_q;
   logic [NUM_THREADS-1:0] rsp_tmask_q;
   logic                   rsp_redirect_q;
   logic [PC_W-1:0]        rsp_pc_q;
   logic                   rsp_err_q;

   logic [NUM_THREADS-1:0] rsp_tmask_d;
   logic                   rsp_redirect_d;
   logic [PC_W-1:0]        rsp_pc_d;
   logic                   rsp_err_d;

   logic [NUM_THREADS-1:0] taken_lanes;
   logic [NUM_THREADS-1:0] else_lanes;
   logic                   divergent;
   logic                   push;
   logic                   pop;
   sj_entry_t              top_ent;
   sj_entry_t              push_q1;
   sj_entry_t              push_q2;

   logic [ENT_W-1:0]       stk_d [NUM_WARPS];
   logic [NUM_WARPS-1:0]   stk_full;
   logic [NUM_WARPS-1:0]   stk_empty;
   logic [NUM_WARPS-1:0]   stk_push;
   logic [NUM_WARPS-1:0]   stk_pop;

   // Stack reset asserts with reset_n and releases two clocks after it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stk_rst_meta_q <= 1'b1;
         stk_reset_q    <= 1'b1;
      end else begin
         stk_rst_meta_q <= 1'b0;
         stk_reset_q    <= stk_rst_meta_q;
      end
   end

   assign stk_reset = stk_reset_q;

   assign push_q1 = '{fallthru: 1'b1, mask: tmask_q,    pc: '0};
   assign push_q2 = '{fallthru: 1'b0, mask: else_lanes, pc: else_pc_q};

   for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_stack
      assign stk_push[gi] = push && (wid_q == WID_W'(gi));
      assign stk_pop[gi]  = pop  && (wid_q == WID_W'(gi));

      VX_ipdom_stack #(
         .WIDTH (ENT_W),
         .DEPTH (STACK_DEPTH)
      ) u_stack (
         .clk_i   (clk),
         .reset_i (stk_reset),
         .push_i  (stk_push[gi]),
         .pop_i   (stk_pop[gi]),
         .q1_i    (push_q1),
         .q2_i    (push_q2),
         .d_o     (stk_d[gi]),
         .full_o  (stk_full[gi]),
         .empty_o (stk_empty[gi])
      );
   end

   always_comb begin
      taken_lanes    = tmask_q & taken_q;
      else_lanes     = tmask_q & ~taken_q;
      divergent      = (|taken_lanes) && (|else_lanes);
      top_ent        = sj_entry_t'(stk_d[wid_q]);
      push           = 1'b0;
      pop            = 1'b0;
      rsp_tmask_d    = tmask_q;
      rsp_redirect_d = 1'b0;
      rsp_pc_d       = '0;
      rsp_err_d      = 1'b0;
      if (op_q == OP_SPLIT) begin
         if (divergent) begin
            if (stk_full[wid_q]) begin
               rsp_err_d = 1'b1;
            end else begin
               push        = (state_q == ST_EXEC);
               rsp_tmask_d = taken_lanes;
            end
         end
      end else if (!stk_empty[wid_q]) begin
         pop         = (state_q == ST_EXEC);
         rsp_tmask_d = top_ent.mask;
         if (!top_ent.fallthru) begin
            rsp_redirect_d = 1'b1;
            rsp_pc_d       = top_ent.pc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         req_ready_q    <= 1'b0;
         op_q           <= OP_SPLIT;
         wid_q          <= '0;
         tmask_q        <= '0;
         taken_q        <= '0;
         else_pc_q      <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_wid_q      <= '0;
         rsp_tmask_q    <= '0;
         rsp_redirect_q <= 1'b0;
         rsp_pc_q       <= '0;
         rsp_err_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_ready_q && req_valid) begin
                  op_q        <= op_e'(req_op);
                  wid_q       <= req_wid;
                  tmask_q     <= req_tmask;
                  taken_q     <= req_taken;
                  else_pc_q   <= req_else_pc;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_EXEC;
               end else begin
                  req_ready_q <= ~stk_reset;
               end
            end
            ST_EXEC: begin
               rsp_valid_q    <= 1'b1;
               rsp_wid_q      <= wid_q;
               rsp_tmask_q    <= rsp_tmask_d;
               rsp_redirect_q <= rsp_redirect_d;
               rsp_pc_q       <= rsp_pc_d;
               rsp_err_q      <= rsp_err_d;
               state_q        <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_wid      = rsp_wid_q;
   assign rsp_tmask    = rsp_tmask_q;
   assign rsp_redirect = rsp_redirect_q;
   assign rsp_pc       = rsp_pc_q;
   assign rsp_err      = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_split_join_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vx_split_join_ctrl : directed bench for the split/join controller       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vx_split_join_ctrl;

   localparam logic SPLIT = 1'b0;
   localparam logic JOIN  = 1'b1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_op;
   logic [1:0]  req_wid;
   logic [3:0]  req_tmask;
   logic [3:0]  req_taken;
   logic [31:0] req_else_pc;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_wid;
   logic [3:0]  rsp_tmask;
   logic        rsp_redirect;
   logic [31:0] rsp_pc;
   logic        rsp_err;

   int errors = 0;
   int checks = 0;

   logic [1:0]  c_wid;
   logic [3:0]  c_tmask;
   logic        c_redir;
   logic        c_err;
   logic [31:0] c_pc;
   int          c_lat;

   vx_split_join_ctrl #(
      .NUM_WARPS   (4),
      .NUM_THREADS (4),
      .STACK_DEPTH (2),
      .PC_W        (32)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_wid      (req_wid),
      .req_tmask    (req_tmask),
      .req_taken    (req_taken),
      .req_else_pc  (req_else_pc),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_wid      (rsp_wid),
      .rsp_tmask    (rsp_tmask),
      .rsp_redirect (rsp_redirect),
      .rsp_pc       (rsp_pc),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_req(input logic op, input logic [1:0] wid, input logic [3:0] tm,
                           input logic [3:0] tk, input logic [31:0] pc);
      int n = 0;
      @(negedge clk);
      req_valid   = 1'b1;
      req_op      = op;
      req_wid     = wid;
      req_tmask   = tm;
      req_taken   = tk;
      req_else_pc = pc;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL req_accept: req_ready=%0b required 1 within 50 cycles", req_ready);
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_rsp();
      c_lat = 0;
      do begin
         @(negedge clk);
         c_lat++;
      end while (!rsp_valid && c_lat < 50);
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("FAIL rsp_timeout: rsp_valid=%0b required 1 within 50 cycles", rsp_valid);
      end
      c_wid   = rsp_wid;
      c_tmask = rsp_tmask;
      c_redir = rsp_redirect;
      c_err   = rsp_err;
      c_pc    = rsp_pc;
   endtask

   task automatic txn(input logic op, input logic [1:0] wid, input logic [3:0] tm,
                      input logic [3:0] tk, input logic [31:0] pc);
      send_req(op, wid, tm, tk, pc);
      wait_rsp();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL ready_after_reset: req_ready=%0b required 1", req_ready);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_redirect, rsp_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b required 0000",
                  {req_ready, rsp_valid, rsp_redirect, rsp_err});
      end
      checks++;
      if ({rsp_wid, rsp_tmask, rsp_pc} !== 38'd0) begin
         errors++;
         $display("FAIL reset_data: got wid=%0d tmask=%b pc=%h required 0", rsp_wid, rsp_tmask, rsp_pc);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_during_stk_reset: got %b required 0", req_ready);
      end
      wait_ready();
   endtask

   task automatic test_split_join();
      txn(SPLIT, 2'd0, 4'b1111, 4'b0011, 32'h100);
      checks++;
      if ({c_wid, c_tmask, c_redir, c_err} !== {2'd0, 4'b0011, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL div_split: got wid=%0d tmask=%b redir=%b err=%b required 0/0011/0/0",
                  c_wid, c_tmask, c_redir, c_err);
      end
      checks++;
      if (c_lat != 2) begin
         errors++;
         $display("FAIL latency: got %0d cycles required 2", c_lat);
      end
      txn(JOIN, 2'd0, 4'b0011, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_err, c_pc} !== {4'b1100, 1'b1, 1'b0, 32'h100}) begin
         errors++;
         $display("FAIL join_else: got tmask=%b redir=%b err=%b pc=%h required 1100/1/0/100",
                  c_tmask, c_redir, c_err, c_pc);
      end
      txn(JOIN, 2'd0, 4'b1100, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_err} !== {4'b1111, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL join_fallthru: got tmask=%b redir=%b err=%b required 1111/0/0",
                  c_tmask, c_redir, c_err);
      end
      txn(JOIN, 2'd0, 4'b0011, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_err} !== {4'b0011, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL join_empty: got tmask=%b redir=%b err=%b required 0011/0/0",
                  c_tmask, c_redir, c_err);
      end
   endtask

   task automatic test_uniform();
      logic [3:0] tm [3] = '{4'b1111, 4'b1111, 4'b0110};
      logic [3:0] tk [3] = '{4'b1111, 4'b0000, 4'b0110};
      for (int i = 0; i < 3; i++) begin
         txn(SPLIT, 2'd0, tm[i], tk[i], 32'h44);
         checks++;
         if ({c_tmask, c_redir, c_err} !== {tm[i], 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL uniform_split[%0d]: got tmask=%b redir=%b err=%b required %b/0/0",
                     i, c_tmask, c_redir, c_err, tm[i]);
         end
      end
      txn(JOIN, 2'd0, 4'b1010, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_err} !== {4'b1010, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL uniform_join_empty: got tmask=%b redir=%b err=%b required 1010/0/0",
                  c_tmask, c_redir, c_err);
      end
   endtask

   task automatic test_overflow();
      logic [3:0]  tk  [4] = '{4'b0011, 4'b0101, 4'b0110, 4'b0001};
      logic [31:0] epc [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
      logic [3:0]  j_tm  [7] = '{4'b1001, 4'b1111, 4'b1010, 4'b1111, 4'b1100, 4'b1111, 4'b0111};
      logic        j_rd  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] j_pc  [7] = '{32'hC, 32'h0, 32'hB, 32'h0, 32'hA, 32'h0, 32'h0};
      for (int i = 0; i < 3; i++) begin
         txn(SPLIT, 2'd1, 4'b1111, tk[i], epc[i]);
         checks++;
         if ({c_wid, c_tmask, c_redir, c_err} !== {2'd1, tk[i], 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_split[%0d]: got wid=%0d tmask=%b redir=%b err=%b required 1/%b/0/0",
                     i, c_wid, c_tmask, c_redir, c_err, tk[i]);
         end
      end
      txn(SPLIT, 2'd1, 4'b1111, tk[3], epc[3]);
      checks++;
      if ({c_tmask, c_redir, c_err} !== {4'b1111, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL ovf_full: got tmask=%b redir=%b err=%b required 1111/0/1",
                  c_tmask, c_redir, c_err);
      end
      for (int i = 0; i < 7; i++) begin
         txn(JOIN, 2'd1, 4'b0111, 4'b0000, 32'h0);
         checks++;
         if ({c_tmask, c_redir, c_err} !== {j_tm[i], j_rd[i], 1'b0} ||
             (j_rd[i] && c_pc !== j_pc[i])) begin
            errors++;
            $display("FAIL ovf_join[%0d]: got tmask=%b redir=%b err=%b pc=%h required %b/%b/0/%h",
                     i, c_tmask, c_redir, c_err, c_pc, j_tm[i], j_rd[i], j_pc[i]);
         end
      end
   endtask

   task automatic test_isolation();
      txn(SPLIT, 2'd2, 4'b1111, 4'b1000, 32'h200);
      checks++;
      if ({c_wid, c_tmask, c_redir} !== {2'd2, 4'b1000, 1'b0}) begin
         errors++;
         $display("FAIL iso_split: got wid=%0d tmask=%b redir=%b required 2/1000/0", c_wid, c_tmask, c_redir);
      end
      txn(JOIN, 2'd3, 4'b0101, 4'b0000, 32'h0);
      checks++;
      if ({c_wid, c_tmask, c_redir, c_err} !== {2'd3, 4'b0101, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL iso_other_warp: got wid=%0d tmask=%b redir=%b err=%b required 3/0101/0/0",
                  c_wid, c_tmask, c_redir, c_err);
      end
      txn(JOIN, 2'd2, 4'b1000, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_pc} !== {4'b0111, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL iso_join_else: got tmask=%b redir=%b pc=%h required 0111/1/200", c_tmask, c_redir, c_pc);
      end
      txn(JOIN, 2'd2, 4'b0111, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir} !== {4'b1111, 1'b0}) begin
         errors++;
         $display("FAIL iso_join_fallthru: got tmask=%b redir=%b required 1111/0", c_tmask, c_redir);
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      send_req(SPLIT, 2'd0, 4'b1111, 4'b0011, 32'h300);
      wait_rsp();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, req_ready, rsp_wid, rsp_tmask, rsp_redirect, rsp_err} !==
             {1'b1, 1'b0, 2'd0, 4'b0011, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b ready=%b wid=%0d tmask=%b redir=%b err=%b required 1/0/0/0011/0/0",
                     i, rsp_valid, req_ready, rsp_wid, rsp_tmask, rsp_redirect, rsp_err);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      txn(JOIN, 2'd0, 4'b0011, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_pc} !== {4'b1100, 1'b1, 32'h300}) begin
         errors++;
         $display("FAIL bp_join_else: got tmask=%b redir=%b pc=%h required 1100/1/300", c_tmask, c_redir, c_pc);
      end
      txn(JOIN, 2'd0, 4'b1100, 4'b0000, 32'h0);
      txn(JOIN, 2'd0, 4'b0110, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir} !== {4'b0110, 1'b0}) begin
         errors++;
         $display("FAIL bp_single_push: got tmask=%b redir=%b required 0110/0", c_tmask, c_redir);
      end
   endtask

   task automatic test_reset_mid();
      txn(SPLIT, 2'd1, 4'b1111, 4'b0101, 32'h500);
      send_req(SPLIT, 2'd1, 4'b1111, 4'b0011, 32'h600);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, req_ready} !== 2'b00) begin
         errors++;
         $display("FAIL mid_reset_drop: got valid=%b ready=%b required 0/0", rsp_valid, req_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wait_ready();
      txn(JOIN, 2'd1, 4'b0110, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_err} !== {4'b0110, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_w1: got tmask=%b redir=%b err=%b required 0110/0/0", c_tmask, c_redir, c_err);
      end
      txn(JOIN, 2'd0, 4'b1001, 4'b0000, 32'h0);
      checks++;
      if ({c_tmask, c_redir, c_err} !== {4'b1001, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_w0: got tmask=%b redir=%b err=%b required 1001/0/0", c_tmask, c_redir, c_err);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      req_valid   = 1'b0;
      req_op      = 1'b0;
      req_wid     = 2'd0;
      req_tmask   = 4'd0;
      req_taken   = 4'd0;
      req_else_pc = 32'd0;
      rsp_ready   = 1'b1;
      test_reset();
      test_split_join();
      test_uniform();
      test_overflow();
      test_isolation();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
